// File: rtl/rvfi_retire_serializer.sv
// Reorders multi-channel RVFI retirements by rvfi_order and replays them one at
// a time on a valid/ready port for single-channel sequential checkers.
module rvfi_retire_serializer #(
  parameter int NRET  = 2,
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NRET-1:0]           in_valid,
  input  logic [NRET*8-1:0]         in_order,
  input  logic [NRET*32-1:0]        in_insn,
  input  logic [NRET*XLEN-1:0]      in_pre_pc,
  input  logic [NRET*XLEN-1:0]      in_post_pc,
  input  logic [NRET-1:0]           in_trap,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_order,
  output logic [31:0]               out_insn,
  output logic [XLEN-1:0]           out_pre_pc,
  output logic [XLEN-1:0]           out_post_pc,
  output logic                      out_trap,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      err_window,
  output logic                      err_dup
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_valid;
  logic [7:0]       r_order   [DEPTH];
  logic [31:0]      r_insn    [DEPTH];
  logic [XLEN-1:0]  r_pre_pc  [DEPTH];
  logic [XLEN-1:0]  r_post_pc [DEPTH];
  logic [DEPTH-1:0] r_trap;
  logic [7:0]       r_next_order;
  logic [AW:0]      r_occ;
  logic             r_err_window;
  logic             r_err_dup;

  logic [AW-1:0]    w_head;
  logic             w_fire;
  logic [7:0]       w_dist [NRET];
  logic [AW-1:0]    w_slot [NRET];
  logic [NRET-1:0]  w_inwin;
  logic [NRET-1:0]  w_conf;
  logic [NRET-1:0]  w_acc;
  logic [NRET-1:0]  w_drop_win;
  logic [NRET-1:0]  w_drop_dup;
  logic [AW:0]      w_nacc;

  assign w_head = r_next_order[AW-1:0];
  assign w_fire = r_valid[w_head] & out_ready;

  // A slot about to be popped still counts as occupied; its only in-window
  // successor would be next_order+DEPTH, which the window check already rejects.
  always_comb begin
    w_nacc = '0;
    for (int i = 0; i < NRET; i++) begin
      w_dist[i]  = in_order[i*8 +: 8] - r_next_order;
      w_slot[i]  = in_order[i*8 +: AW];
      w_inwin[i] = (w_dist[i] < 8'(DEPTH));
    end
    for (int i = 0; i < NRET; i++) begin
      w_conf[i] = r_valid[w_slot[i]];
      for (int j = 0; j < NRET; j++) begin
        if (j < i && in_valid[j] && w_inwin[j] && (w_slot[j] == w_slot[i]))
          w_conf[i] = 1'b1;
      end
      w_acc[i]      = in_valid[i] & w_inwin[i] & ~w_conf[i];
      w_drop_win[i] = in_valid[i] & ~w_inwin[i];
      w_drop_dup[i] = in_valid[i] & w_inwin[i] & w_conf[i];
      w_nacc        = w_nacc + {{AW{1'b0}}, w_acc[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= '0;
      r_next_order <= '0;
      r_occ        <= '0;
      r_err_window <= 1'b0;
      r_err_dup    <= 1'b0;
    end else begin
      if (w_fire) begin
        r_valid[w_head] <= 1'b0;
        r_next_order    <= r_next_order + 8'd1;
      end
      for (int i = 0; i < NRET; i++) begin
        if (w_acc[i]) r_valid[w_slot[i]] <= 1'b1;
      end
      r_occ <= r_occ + w_nacc - {{AW{1'b0}}, w_fire};
      if (|w_drop_win) r_err_window <= 1'b1;
      if (|w_drop_dup) r_err_dup    <= 1'b1;
    end
  end

  // Payload is qualified by r_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NRET; i++) begin
      if (w_acc[i]) begin
        r_order[w_slot[i]]   <= in_order[i*8 +: 8];
        r_insn[w_slot[i]]    <= in_insn[i*32 +: 32];
        r_pre_pc[w_slot[i]]  <= in_pre_pc[i*XLEN +: XLEN];
        r_post_pc[w_slot[i]] <= in_post_pc[i*XLEN +: XLEN];
        r_trap[w_slot[i]]    <= in_trap[i];
      end
    end
  end

  assign out_valid   = r_valid[w_head];
  assign out_order   = r_order[w_head];
  assign out_insn    = r_insn[w_head];
  assign out_pre_pc  = r_pre_pc[w_head];
  assign out_post_pc = r_post_pc[w_head];
  assign out_trap    = r_trap[w_head];
  assign occupancy   = r_occ;
  assign err_window  = r_err_window;
  assign err_dup     = r_err_dup;

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Directed bench for rvfi_retire_serializer: ordering, backpressure, window,
// duplicate, wrap and asynchronous reset behaviour.
module tb_rvfi_retire_serializer;

  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NRET-1:0]        in_valid;
  logic [NRET*8-1:0]      in_order;
  logic [NRET*32-1:0]     in_insn;
  logic [NRET*XLEN-1:0]   in_pre_pc;
  logic [NRET*XLEN-1:0]   in_post_pc;
  logic [NRET-1:0]        in_trap;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_order;
  logic [31:0]            out_insn;
  logic [XLEN-1:0]        out_pre_pc;
  logic [XLEN-1:0]        out_post_pc;
  logic                   out_trap;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   err_window;
  logic                   err_dup;

  int n_chk  = 0;
  int n_pass = 0;

  rvfi_retire_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_order(in_order), .in_insn(in_insn),
    .in_pre_pc(in_pre_pc), .in_post_pc(in_post_pc), .in_trap(in_trap),
    .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
    .out_insn(out_insn), .out_pre_pc(out_pre_pc), .out_post_pc(out_post_pc),
    .out_trap(out_trap), .occupancy(occupancy),
    .err_window(err_window), .err_dup(err_dup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] f_insn(input logic [7:0] ord);
    return 32'h0000_0013 | ({24'b0, ord} << 8);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = '0; in_order = '0; in_insn = '0;
    in_pre_pc = '0; in_post_pc = '0; in_trap = '0;
  endtask

  task automatic drive(input int ch, input logic [7:0] ord, input logic [31:0] insn);
    in_valid[ch]               = 1'b1;
    in_order[ch*8 +: 8]        = ord;
    in_insn[ch*32 +: 32]       = insn;
    in_pre_pc[ch*XLEN +: XLEN] = {24'b0, ord} << 2;
    in_post_pc[ch*XLEN +: XLEN] = ({24'b0, ord} << 2) + 32'd4;
    in_trap[ch]                = (ord == 8'd5);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    clear_in();
    tick();
    #2 reset = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [7:0] ord);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".order"}, {24'b0, out_order}, {24'b0, ord});
    chk({tag, ".insn"}, out_insn, f_insn(ord));
    chk({tag, ".pre_pc"}, out_pre_pc, {24'b0, ord} << 2);
    chk({tag, ".post_pc"}, out_post_pc, ({24'b0, ord} << 2) + 32'd4);
    chk({tag, ".trap"}, {31'b0, out_trap}, {31'b0, (ord == 8'd5)});
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    clear_in();
    tick();
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.occ", 32'(occupancy), 32'd0);
    chk("rst.errw", {31'b0, err_window}, 32'd0);
    chk("rst.errd", {31'b0, err_dup}, 32'd0);
    #2 reset = 1'b0;

    // same-cycle pair
    tick();
    out_ready = 1'b1;
    drive(0, 8'd0, f_insn(8'd0));
    drive(1, 8'd1, f_insn(8'd1));
    tick();
    clear_in();
    chk_head("pair0", 8'd0);
    chk("pair.occ2", 32'(occupancy), 32'd2);
    tick();
    chk_head("pair1", 8'd1);
    chk("pair.occ1", 32'(occupancy), 32'd1);
    tick();
    chk("pair.empty", {31'b0, out_valid}, 32'd0);
    chk("pair.occ0", 32'(occupancy), 32'd0);
    chk("pair.errw", {31'b0, err_window}, 32'd0);
    chk("pair.errd", {31'b0, err_dup}, 32'd0);

    // out-of-order arrival
    do_reset();
    out_ready = 1'b1;
    drive(1, 8'd1, f_insn(8'd1));
    tick();
    clear_in();
    chk("ooo.wait1", {31'b0, out_valid}, 32'd0);
    tick();
    chk("ooo.wait2", {31'b0, out_valid}, 32'd0);
    drive(0, 8'd0, f_insn(8'd0));
    tick();
    clear_in();
    chk_head("ooo0", 8'd0);
    tick();
    chk_head("ooo1", 8'd1);
    tick();
    chk("ooo.empty", {31'b0, out_valid}, 32'd0);

    // backpressure, full window, overflow
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(0, 8'(k), f_insn(8'(k)));
      tick();
      clear_in();
    end
    chk("full.occ", 32'(occupancy), 32'd8);
    chk_head("full.hold", 8'd0);
    tick();
    chk_head("full.stable", 8'd0);
    drive(0, 8'd8, f_insn(8'd8));
    tick();
    clear_in();
    chk("full.errw", {31'b0, err_window}, 32'd1);
    chk("full.errd", {31'b0, err_dup}, 32'd0);
    chk("full.occ_after", 32'(occupancy), 32'd8);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk_head($sformatf("drain%0d", k), 8'(k));
      tick();
    end
    chk("drain.empty", {31'b0, out_valid}, 32'd0);
    chk("drain.occ", 32'(occupancy), 32'd0);

    // duplicates: same-cycle on both channels, then repeated next cycle
    do_reset();
    out_ready = 1'b0;
    drive(0, 8'd3, 32'hAAAA_0003);
    drive(1, 8'd3, 32'hBBBB_0003);
    tick();
    clear_in();
    chk("dup.errd", {31'b0, err_dup}, 32'd1);
    chk("dup.errw", {31'b0, err_window}, 32'd0);
    chk("dup.occ1", 32'(occupancy), 32'd1);
    drive(0, 8'd3, 32'hCCCC_0003);
    tick();
    clear_in();
    chk("dup.occ_again", 32'(occupancy), 32'd1);
    drive(0, 8'd0, f_insn(8'd0));
    drive(1, 8'd1, f_insn(8'd1));
    tick();
    clear_in();
    drive(0, 8'd2, f_insn(8'd2));
    tick();
    clear_in();
    chk("dup.occ4", 32'(occupancy), 32'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk_head($sformatf("dup.seq%0d", k), 8'(k));
      tick();
    end
    chk("dup.v3", {31'b0, out_valid}, 32'd1);
    chk("dup.o3", {24'b0, out_order}, 32'd3);
    chk("dup.insn3", out_insn, 32'hAAAA_0003);
    tick();
    chk("dup.once", {31'b0, out_valid}, 32'd0);
    chk("dup.occ0", 32'(occupancy), 32'd0);

    // order wrap 255 -> 0
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 260; k++) begin
      drive(0, 8'(k % 256), f_insn(8'(k % 256)));
      tick();
      clear_in();
      chk($sformatf("wrap%0d", k), {23'b0, out_valid, out_order}, {23'b0, 1'b1, 8'(k % 256)});
    end
    chk("wrap.insn", out_insn, f_insn(8'd3));
    tick();
    chk("wrap.empty", {31'b0, out_valid}, 32'd0);
    chk("wrap.errw", {31'b0, err_window}, 32'd0);
    chk("wrap.errd", {31'b0, err_dup}, 32'd0);
    chk("wrap.occ", 32'(occupancy), 32'd0);

    // asynchronous reset with buffered packets
    do_reset();
    out_ready = 1'b0;
    drive(0, 8'd0, f_insn(8'd0)); drive(1, 8'd1, f_insn(8'd1));
    tick(); clear_in();
    drive(0, 8'd2, f_insn(8'd2)); drive(1, 8'd3, f_insn(8'd3));
    tick(); clear_in();
    drive(0, 8'd4, f_insn(8'd4)); drive(1, 8'd20, f_insn(8'd20));
    tick(); clear_in();
    chk("arst.pre_occ", 32'(occupancy), 32'd5);
    chk("arst.pre_errw", {31'b0, err_window}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst.valid", {31'b0, out_valid}, 32'd0);
    chk("arst.occ", 32'(occupancy), 32'd0);
    chk("arst.errw", {31'b0, err_window}, 32'd0);
    chk("arst.errd", {31'b0, err_dup}, 32'd0);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("arst.idle", {31'b0, out_valid}, 32'd0);
    drive(0, 8'd0, f_insn(8'd0));
    tick();
    clear_in();
    chk_head("arst.fresh", 8'd0);
    chk("arst.occ1", 32'(occupancy), 32'd1);
    tick();
    chk("arst.done", {31'b0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_serializer.md
Name: rvfi_retire_serializer

Overview:
- Collects retirement packets from all NRET RVFI channels and buffers them in a small reorder window indexed by rvfi_order.
- Emits the packets one per transfer, in strict ascending order, on a single-channel valid/ready port.
- Sits between a multi-retire core's RVFI bus and single-channel sequential checkers, such as the PC-continuity check.
- Sequences those checkers so they never see out-of-order or simultaneous retirements, and flags packets that cannot be placed.

Parameters:
NRET, 2, number of RVFI retire channels
XLEN, 32, architectural register/PC width
DEPTH, 8, reorder window slots; power of two, 2..64

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  NRET  per-channel retire valid
in_order  input  NRET*8  per-channel retirement index
in_insn  input  NRET*32  per-channel instruction word
in_pre_pc  input  NRET*XLEN  per-channel PC before instruction
in_post_pc  input  NRET*XLEN  per-channel PC after instruction
in_trap  input  NRET  per-channel trap flag
out_valid  output  1  head packet available
out_ready  input  1  consumer accepts head packet
out_order  output  8  head packet order
out_insn  output  32  head packet insn
out_pre_pc  output  XLEN  head packet pre_pc
out_post_pc  output  XLEN  head packet post_pc
out_trap  output  1  head packet trap
occupancy  output  $clog2(DEPTH)+1  number of valid slots
err_window  output  1  sticky: packet outside reorder window dropped
err_dup  output  1  sticky: packet collided with occupied slot or same-cycle duplicate, dropped

Behaviour:
State:
- DEPTH slots, each holding {valid, order, insn, pre_pc, post_pc, trap}.
- 8-bit next_order counter.
- occupancy counter.
- Two sticky error flags.

Reset (async assert, sync-safe deassert):
- All slot valid bits cleared; next_order=0; occupancy=0; err_window=0; err_dup=0.
- out_valid=0. Other out_* fields don't-care while out_valid=0.
- Reset mid-operation discards all buffered packets; no packet is emitted after reset until a new order 0 arrives.

Write side (each channel i with in_valid[i]=1, evaluated each cycle):
- dist = (in_order[i] - next_order) mod 256, using the pre-edge value of next_order.
- dist >= DEPTH: packet dropped, err_window set next edge.
- Otherwise slot s = in_order[i] mod DEPTH.
  - Slot already valid, or a lower-index channel targets the same s this cycle: packet dropped, err_dup set. The lower channel or the existing entry wins.
  - Otherwise the slot is written on the edge with valid=1.
- A slot being popped this cycle counts as occupied for write checks. Its successor order next_order+DEPTH has dist=DEPTH, so it is rejected as err_window.

Read side (combinational from registers):
- Head slot h = next_order mod DEPTH.
- out_valid = slot[h].valid; out_* = slot[h] fields.
- Fire = out_valid & out_ready: slot[h].valid cleared, next_order increments (wraps 255 -> 0).
- out_valid may be held across cycles; out_* stay stable while out_valid=1 and out_ready=0.
- No combinational path from in_* to out_*: a packet written at edge N is presentable at cycle N+1 at the earliest.

Occupancy:
- Next value = occupancy + accepted writes - fire.
- Never exceeds DEPTH.

Errors:
- Sticky until reset.
- No input backpressure exists (RVFI cannot stall); overflow manifests only as err_window.

Test Plan:
- Reset, then ch0 order0 and ch1 order1 in the same cycle, out_ready=1 -> next cycle out_order=0, then out_order=1; occupancy 2,1,0; no errors.
- Out-of-order arrival: ch1 order1 at cycle1, ch0 order0 at cycle3 -> out_valid stays 0 until cycle4, then emits 0 then 1.
- out_ready=0 while orders 0..7 arrive -> occupancy=8, out_order=0 held stable. Order 8 arrives -> dropped, err_window=1. Release ready -> 0..7 emitted in sequence.
- Order 3 presented twice, in the same cycle on ch0/ch1 and again one cycle later -> ch0 copy kept, err_dup=1, exactly one order-3 packet emitted.
- Wrap: drive orders 0..255 then 0..3 with ready=1 -> output sequence continuous across 255 -> 0, no errors.
- Reset asserted asynchronously with 5 packets buffered -> out_valid=0 and occupancy=0 immediately, errors cleared. Fresh order 0 after deassert is emitted normally.
